// File: rtl/alu_op_sequencer_if.sv
// Bundle of the sequencer's instruction handshake, register-file port set and ALU port set.
// The master modport is the sequencer; the slave modport is the surrounding datapath.
interface alu_op_sequencer_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
);
  logic              InValid;
  logic              InReady;
  logic [3:0]        InOp;
  logic [ADDR_W-1:0] InRs;
  logic [ADDR_W-1:0] InRt;
  logic [ADDR_W-1:0] InRd;
  logic [4:0]        InShamt;
  logic              InWbEn;
  logic [ADDR_W-1:0] RR1;
  logic [ADDR_W-1:0] RR2;
  logic [DATA_W-1:0] Rd1;
  logic [DATA_W-1:0] Rd2;
  logic [DATA_W-1:0] AluA;
  logic [DATA_W-1:0] AluB;
  logic [3:0]        AluOp;
  logic [4:0]        AluShift;
  logic [DATA_W-1:0] AluResult;
  logic              AluZero;
  logic [ADDR_W-1:0] WR;
  logic [DATA_W-1:0] WD;
  logic              WE;
  logic              Done;
  logic [DATA_W-1:0] ResultOut;
  logic              ZeroFlag;
  logic              IllegalOp;
  logic [CNT_W-1:0]  RetireCount;

  modport master (
    input  InValid, InOp, InRs, InRt, InRd, InShamt, InWbEn,
    input  Rd1, Rd2, AluResult, AluZero,
    output InReady, RR1, RR2, AluA, AluB, AluOp, AluShift,
    output WR, WD, WE, Done, ResultOut, ZeroFlag, IllegalOp, RetireCount
  );

  modport slave (
    output InValid, InOp, InRs, InRt, InRd, InShamt, InWbEn,
    output Rd1, Rd2, AluResult, AluZero,
    input  InReady, RR1, RR2, AluA, AluB, AluOp, AluShift,
    input  WR, WD, WE, Done, ResultOut, ZeroFlag, IllegalOp, RetireCount
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Multi-cycle micro-instruction sequencer: register read, ALU execute and write-back,
// one instruction every three cycles, with a new accept overlapping the write-back cycle.
module alu_op_sequencer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input logic                Clk,
  input logic                Rst,
  alu_op_sequencer_if.master bus
);

  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

  state_t            state;
  logic [3:0]        op_q;
  logic [ADDR_W-1:0] rs_q;
  logic [ADDR_W-1:0] rt_q;
  logic [ADDR_W-1:0] rd_q;
  logic [4:0]        shamt_q;
  logic              wb_en_q;
  logic [DATA_W-1:0] opa_q;
  logic [DATA_W-1:0] opb_q;
  logic [DATA_W-1:0] res_q;
  logic              zero_q;
  logic [DATA_W-1:0] result_out_q;
  logic              zero_flag_q;
  logic [CNT_W-1:0]  retire_q;

  logic accept;
  logic legal_op;
  logic in_wb;

  assign accept   = bus.InValid && bus.InReady;
  assign legal_op = (op_q <= 4'd8);
  // NOTE: gating with Rst keeps a write or Done from escaping in the cycle the instruction is dropped.
  assign in_wb    = (state == WB) && !Rst;

  assign bus.InReady     = (state == IDLE) || (state == WB);
  assign bus.RR1         = rs_q;
  assign bus.RR2         = rt_q;
  assign bus.AluA        = opa_q;
  assign bus.AluB        = opb_q;
  assign bus.AluOp       = op_q;
  assign bus.AluShift    = shamt_q;
  assign bus.WR          = rd_q;
  assign bus.WD          = res_q;
  assign bus.WE          = in_wb && wb_en_q && legal_op;
  assign bus.Done        = in_wb;
  assign bus.IllegalOp   = in_wb && !legal_op;
  assign bus.ResultOut   = result_out_q;
  assign bus.ZeroFlag    = zero_flag_q;
  assign bus.RetireCount = retire_q;

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state        <= IDLE;
      op_q         <= '0;
      rs_q         <= '0;
      rt_q         <= '0;
      rd_q         <= '0;
      shamt_q      <= '0;
      wb_en_q      <= 1'b0;
      opa_q        <= '0;
      opb_q        <= '0;
      res_q        <= '0;
      zero_q       <= 1'b0;
      result_out_q <= '0;
      zero_flag_q  <= 1'b0;
      retire_q     <= '0;
    end else begin
      if (accept) begin
        op_q    <= bus.InOp;
        rs_q    <= bus.InRs;
        rt_q    <= bus.InRt;
        rd_q    <= bus.InRd;
        shamt_q <= bus.InShamt;
        wb_en_q <= bus.InWbEn;
      end
      case (state)
        IDLE: state <= accept ? READ : IDLE;
        READ: begin
          opa_q <= bus.Rd1;
          opb_q <= bus.Rd2;
          state <= EXEC;
        end
        EXEC: begin
          res_q  <= bus.AluResult;
          zero_q <= bus.AluZero;
          state  <= WB;
        end
        WB: begin
          result_out_q <= res_q;
          zero_flag_q  <= zero_q;
          retire_q     <= retire_q + CNT_W'(1);
          state        <= accept ? READ : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural register file and ALU around it.
module tb_alu_op_sequencer;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = 2;

  logic Clk;
  logic Rst;
  logic init_rf;
  int   n_checks;
  int   n_errors;

  logic [DATA_W-1:0] regs [32];

  alu_op_sequencer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

  alu_op_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Register file: preload under init_rf, otherwise write on WE at the clock edge.
  always @(posedge Clk) begin
    if (init_rf) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
      regs[3]  <= -32'sd2000;
      regs[31] <= 32'sd1300;
    end else if (bus.WE) begin
      regs[bus.WR] <= bus.WD;
    end
  end

  assign bus.Rd1 = regs[bus.RR1];
  assign bus.Rd2 = regs[bus.RR2];

  // ALU model; zero is taken as operand equality, as for a branch compare.
  always_comb begin
    case (bus.AluOp)
      4'd0:    bus.AluResult = bus.AluA + bus.AluB;
      4'd1:    bus.AluResult = bus.AluA - bus.AluB;
      4'd2:    bus.AluResult = bus.AluA & bus.AluB;
      4'd3:    bus.AluResult = bus.AluA | bus.AluB;
      4'd4:    bus.AluResult = bus.AluA << bus.AluShift;
      4'd5:    bus.AluResult = bus.AluA >> bus.AluShift;
      4'd6:    bus.AluResult = $unsigned($signed(bus.AluA) >>> bus.AluShift);
      4'd7:    bus.AluResult = {31'b0, $signed(bus.AluA) > $signed(bus.AluB)};
      4'd8:    bus.AluResult = {31'b0, $signed(bus.AluA) < $signed(bus.AluB)};
      default: bus.AluResult = '0;
    endcase
    bus.AluZero = (bus.AluA == bus.AluB);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [4:0] shamt, input logic wb);
    bus.InValid = 1'b1;
    bus.InOp    = op;
    bus.InRs    = rs;
    bus.InRt    = rt;
    bus.InRd    = rd;
    bus.InShamt = shamt;
    bus.InWbEn  = wb;
  endtask

  // Returns #1 after the accepting edge.
  task automatic wait_accept(input string tag);
    int n = 0;
    while (!bus.InReady && n < 20) begin
      @(negedge Clk);
      n++;
    end
    check({tag, ".accept"}, 32'(bus.InReady), 32'd1);
    @(posedge Clk);
    #1;
  endtask

  // Called #1 after the accept edge; ends at the WB-cycle negedge.
  task automatic exec_checks(input string tag, input logic [4:0] rr1, input logic [4:0] rr2,
                             input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                             input logic [4:0] sh, input logic [4:0] wr, input logic [31:0] wd,
                             input logic we, input logic ill);
    @(negedge Clk);
    check({tag, ".rr1"}, 32'(bus.RR1), 32'(rr1));
    check({tag, ".rr2"}, 32'(bus.RR2), 32'(rr2));
    check({tag, ".rd_ready"}, 32'(bus.InReady), 32'd0);
    check({tag, ".rd_we"}, 32'(bus.WE), 32'd0);
    check({tag, ".rd_done"}, 32'(bus.Done), 32'd0);
    @(negedge Clk);
    check({tag, ".alua"}, bus.AluA, a);
    check({tag, ".alub"}, bus.AluB, b);
    check({tag, ".aluop"}, 32'(bus.AluOp), 32'(op));
    check({tag, ".alushift"}, 32'(bus.AluShift), 32'(sh));
    check({tag, ".ex_ready"}, 32'(bus.InReady), 32'd0);
    check({tag, ".ex_we"}, 32'(bus.WE), 32'd0);
    @(negedge Clk);
    check({tag, ".we"}, 32'(bus.WE), 32'(we));
    check({tag, ".wr"}, 32'(bus.WR), 32'(wr));
    check({tag, ".wd"}, bus.WD, wd);
    check({tag, ".done"}, 32'(bus.Done), 32'd1);
    check({tag, ".illegal"}, 32'(bus.IllegalOp), 32'(ill));
    check({tag, ".wb_ready"}, 32'(bus.InReady), 32'd1);
  endtask

  task automatic retire_checks(input string tag, input logic [31:0] res, input logic zero,
                               input logic [CNT_W-1:0] cnt);
    check({tag, ".result"}, bus.ResultOut, res);
    check({tag, ".zero"}, 32'(bus.ZeroFlag), 32'(zero));
    check({tag, ".count"}, 32'(bus.RetireCount), 32'(cnt));
    check({tag, ".done_after"}, 32'(bus.Done), 32'd0);
  endtask

  task automatic run(input string tag, input logic [3:0] op, input logic [4:0] rs,
                     input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh,
                     input logic [31:0] a, input logic [31:0] b, input logic [31:0] wd,
                     input logic we, input logic ill, input logic zero,
                     input logic [CNT_W-1:0] cnt);
    drive(op, rs, rt, rd, sh, 1'b1);
    wait_accept(tag);
    bus.InValid = 1'b0;
    exec_checks(tag, rs, rt, a, b, op, sh, rd, wd, we, ill);
    @(posedge Clk);
    #1;
    retire_checks(tag, wd, zero, cnt);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    Rst      = 1'b1;
    init_rf  = 1'b1;
    drive(4'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    bus.InValid = 1'b0;

    // Reset
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Rst     = 1'b0;
    init_rf = 1'b0;
    check("rst.ready", 32'(bus.InReady), 32'd1);
    check("rst.we", 32'(bus.WE), 32'd0);
    check("rst.done", 32'(bus.Done), 32'd0);
    check("rst.count", 32'(bus.RetireCount), 32'd0);
    check("rst.result", bus.ResultOut, 32'd0);
    check("rst.alua", bus.AluA, 32'd0);

    // ADD r5 = r3 + r31
    drive(4'd0, 5'd3, 5'd31, 5'd5, 5'd0, 1'b1);
    wait_accept("add");
    bus.InValid = 1'b0;
    exec_checks("add", 5'd3, 5'd31, -32'sd2000, 32'sd1300, 4'd0, 5'd0, 5'd5, -32'sd700, 1'b1, 1'b0);

    // SUB r6 = r5 - r3, accepted during the ADD write-back cycle
    drive(4'd1, 5'd5, 5'd3, 5'd6, 5'd0, 1'b1);
    wait_accept("sub");
    retire_checks("add", -32'sd700, 1'b0, 2'd1);
    bus.InValid = 1'b0;
    exec_checks("sub", 5'd5, 5'd3, -32'sd700, -32'sd2000, 4'd1, 5'd0, 5'd6, 32'sd1300, 1'b1, 1'b0);
    @(posedge Clk);
    #1;
    retire_checks("sub", 32'sd1300, 1'b0, 2'd2);
    check("sub.r6", regs[6], 32'sd1300);

    // Illegal op 10: flows through, no write, still retires
    run("ill", 4'd10, 5'd3, 5'd31, 5'd5, 5'd0, -32'sd2000, 32'sd1300, 32'd0, 1'b0, 1'b1, 1'b0, 2'd3);
    check("ill.r5", regs[5], -32'sd700);

    // Reset during EXEC drops the instruction
    drive(4'd0, 5'd3, 5'd31, 5'd7, 5'd0, 1'b1);
    wait_accept("abort");
    bus.InValid = 1'b0;
    @(negedge Clk);
    check("abort.read_we", 32'(bus.WE), 32'd0);
    @(negedge Clk);
    Rst = 1'b1;
    check("abort.exec_we", 32'(bus.WE), 32'd0);
    @(posedge Clk);
    #1;
    check("abort.ready", 32'(bus.InReady), 32'd1);
    check("abort.count", 32'(bus.RetireCount), 32'd0);
    check("abort.result", bus.ResultOut, 32'd0);
    check("abort.done", 32'(bus.Done), 32'd0);
    @(negedge Clk);
    Rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      check("abort.idle_ready", 32'(bus.InReady), 32'd1);
      check("abort.idle_we", 32'(bus.WE), 32'd0);
    end
    check("abort.r7", regs[7], 32'd0);

    // Counter wrap with CNT_W=2 over five instructions
    run("gt",  4'd7, 5'd3,  5'd31, 5'd8,  5'd0, -32'sd2000, 32'sd1300, 32'd0,      1'b1, 1'b0, 1'b0, 2'd1);
    run("add2", 4'd0, 5'd31, 5'd31, 5'd9,  5'd0, 32'sd1300,  32'sd1300, 32'sd2600,  1'b1, 1'b0, 1'b1, 2'd2);
    run("lt",  4'd8, 5'd3,  5'd31, 5'd10, 5'd0, -32'sd2000, 32'sd1300, 32'd1,      1'b1, 1'b0, 1'b0, 2'd3);
    run("sll", 4'd4, 5'd31, 5'd0,  5'd11, 5'd2, 32'sd1300,  32'd0,     32'sd5200,  1'b1, 1'b0, 1'b0, 2'd0);
    run("sra", 4'd6, 5'd3,  5'd31, 5'd12, 5'd4, -32'sd2000, 32'sd1300, -32'sd125,  1'b1, 1'b0, 1'b0, 2'd1);
    check("gt.r8", regs[8], 32'd0);
    check("add2.r9", regs[9], 32'sd2600);
    check("sll.r11", regs[11], 32'sd5200);
    check("sra.r12", regs[12], -32'sd125);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
